// File: rtl/cdecv_ctrl_pkg.sv
// Shared definitions for the CDECV micro-sequencer: states, opcodes, bus codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state enum, opcode constants, X-bus source codes, write-enable bit
// indices, ALU operation codes (also used by the ALU) and the decode class enum.
package cdecv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_F2   = 4'd3,
        ST_IM0  = 4'd4,
        ST_IM1  = 4'd5,
        ST_OPND = 4'd6,
        ST_ALU0 = 4'd7,
        ST_ALU1 = 4'd8,
        ST_ADDR = 4'd9,
        ST_LD   = 4'd10,
        ST_ST0  = 4'd11,
        ST_ST1  = 4'd12,
        ST_JMP  = 4'd13,
        ST_HALT = 4'd14
    } state_e;

    // Opcodes, I[7:4]
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_JS  = 4'hD;

    // X-bus source codes
    localparam logic [2:0] XS_PC  = 3'd0;
    localparam logic [2:0] XS_A   = 3'd1;
    localparam logic [2:0] XS_B   = 3'd2;
    localparam logic [2:0] XS_C   = 3'd3;
    localparam logic [2:0] XS_RD  = 3'd4;
    localparam logic [2:0] XS_R   = 3'd5;
    localparam logic [2:0] XS_FLG = 3'd6;
    localparam logic [2:0] XS_FF  = 3'd7;

    // Write-enable bit positions in xdst
    localparam int XD_PC  = 0;
    localparam int XD_A   = 1;
    localparam int XD_B   = 2;
    localparam int XD_C   = 3;
    localparam int XD_MA  = 4;
    localparam int XD_WD  = 5;
    localparam int XD_I   = 6;
    localparam int XD_T   = 7;
    localparam int XD_R   = 8;
    localparam int XD_FLG = 9;

    // ALU operations: operand a = X-bus, operand b = T
    localparam logic [4:0] ALU_PASS_B = 5'd0;
    localparam logic [4:0] ALU_INC    = 5'd1;
    localparam logic [4:0] ALU_ADD    = 5'd2;
    localparam logic [4:0] ALU_SUB    = 5'd3;
    localparam logic [4:0] ALU_AND    = 5'd4;
    localparam logic [4:0] ALU_OR     = 5'd5;
    localparam logic [4:0] ALU_XOR    = 5'd6;

    // Flag bit positions within {S, Z, Cy}
    localparam int FL_CY = 0;
    localparam int FL_Z  = 1;
    localparam int FL_S  = 2;

    // What happens after fetch
    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_HALT = 3'd1,
        CL_ALU  = 3'd2,
        CL_MEM  = 3'd3,
        CL_JMP  = 3'd4
    } iclass_e;

endpackage

// File: rtl/cdecv_control_unit_decode.sv
// Instruction classifier: op/s plus flags -> next-state class, immediate flag, jump condition.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow I and SZCy directly.
// Ports: op_i/s_i instruction fields, flags_i {S,Z,Cy}; cls_o class, imm_o operand
// comes from the byte at PC, is_ld_o LD vs ST, cond_true_o jump condition holds.
module cu_decode
    import cdecv_ctrl_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [1:0] s_i,
    input  logic [2:0] flags_i,
    output iclass_e    cls_o,
    output logic       imm_o,
    output logic       is_ld_o,
    output logic       cond_true_o
);

    always_comb begin
        cls_o = CL_NOP;
        if (op_i == OP_NOP) begin
            cls_o = CL_NOP;
        end else if (op_i <= OP_XOR) begin
            cls_o = CL_ALU;             // MOV and the five ALU ops
        end else if (op_i == OP_LD || op_i == OP_ST) begin
            cls_o = CL_MEM;
        end else if (op_i <= OP_JS) begin
            cls_o = CL_JMP;
        end else begin
            cls_o = CL_HALT;            // E and F
        end
    end

    // NOP never fetches an operand byte even when s = 3
    assign imm_o   = (s_i == 2'd3) && (op_i != OP_NOP);
    assign is_ld_o = (op_i == OP_LD);

    always_comb begin
        cond_true_o = 1'b0;
        case (op_i)
            OP_JMP:  cond_true_o = 1'b1;
            OP_JZ:   cond_true_o = flags_i[FL_Z];
            OP_JNZ:  cond_true_o = !flags_i[FL_Z];
            OP_JC:   cond_true_o = flags_i[FL_CY];
            OP_JS:   cond_true_o = flags_i[FL_S];
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cdecv_control_unit.sv
// CDECV micro-sequencer: fetch/decode/execute, one X-bus transfer per clock, plus memory write strobe.
// Latency: outputs are combinational from the state register, I and SZCy; 3-8 cycles per instruction.
// Backpressure: none; run/step gate instruction start at IDLE only, HALT is left only by reset.
// Ports: clock/reset (sync, active-high); I instruction, SZCy flags; xsrc/xdst/aluop datapath
// controls; mem_we write strobe; run/step debug control; idle/halted/dbg_state status.
module cdecv_control_unit
    import cdecv_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] I,
    input  logic [2:0] SZCy,
    output logic [2:0] xsrc,
    output logic [9:0] xdst,
    output logic [4:0] aluop,
    output logic       mem_we,
    input  logic       run,
    input  logic       step,
    output logic       idle,
    output logic       halted,
    output logic [3:0] dbg_state
);

    state_e     state_q, state_d;
    iclass_e    cls;
    logic       imm, is_ld, cond_true;

    logic [3:0] op;
    logic [1:0] d_f, s_f;
    logic [2:0] src_sel, dst_sel;
    logic [9:0] dst_mask;

    logic [2:0] xsrc_c;
    logic [9:0] xdst_c;
    logic [4:0] aluop_c;
    logic       mem_we_c;
    state_e     end_st, exec_st;

    assign op  = I[7:4];
    assign d_f = I[3:2];
    assign s_f = I[1:0];

    // s = 3 reads the byte at PC, which MA already points at, through RD.
    assign src_sel  = (s_f == 2'd3) ? XS_RD : ({1'b0, s_f} + 3'd1);
    // d = 3 is not a defined register; it maps onto code/bit 4 like any other d.
    assign dst_sel  = {1'b0, d_f} + 3'd1;
    assign dst_mask = 10'd1 << dst_sel;

    cu_decode u_decode (
        .op_i        (op),
        .s_i         (s_f),
        .flags_i     (SZCy),
        .cls_o       (cls),
        .imm_o       (imm),
        .is_ld_o     (is_ld),
        .cond_true_o (cond_true)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        xsrc_c   = XS_PC;
        xdst_c   = '0;
        aluop_c  = ALU_PASS_B;
        mem_we_c = 1'b0;

        // A dropped run lets the current instruction finish, then parks in IDLE.
        end_st = run ? ST_F0 : ST_IDLE;
        case (cls)
            CL_ALU:  exec_st = ST_OPND;
            CL_MEM:  exec_st = ST_ADDR;
            CL_JMP:  exec_st = ST_JMP;
            default: exec_st = end_st;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (run || step) state_d = ST_F0;
            end
            ST_F0, ST_IM0: begin
                // MA <- PC and R <- PC+1 in the same cycle
                xsrc_c         = XS_PC;
                xdst_c[XD_MA]  = 1'b1;
                xdst_c[XD_R]   = 1'b1;
                aluop_c        = ALU_INC;
                state_d        = (state_q == ST_F0) ? ST_F1 : ST_IM1;
            end
            ST_F1: begin
                xsrc_c        = XS_RD;
                xdst_c[XD_I]  = 1'b1;
                state_d       = ST_F2;
            end
            ST_F2: begin
                // I is valid from this cycle, so the instruction is decoded here.
                xsrc_c        = XS_R;
                xdst_c[XD_PC] = 1'b1;
                if (cls == CL_HALT)     state_d = ST_HALT;
                else if (cls == CL_NOP) state_d = end_st;
                else if (imm)           state_d = ST_IM0;
                else                    state_d = exec_st;
            end
            ST_IM1: begin
                xsrc_c        = XS_R;
                xdst_c[XD_PC] = 1'b1;
                state_d       = exec_st;
            end
            ST_OPND: begin
                xsrc_c        = src_sel;
                xdst_c[XD_T]  = 1'b1;
                state_d       = ST_ALU0;
            end
            ST_ALU0: begin
                xsrc_c = dst_sel;
                if (op == OP_MOV) begin
                    aluop_c       = ALU_PASS_B;
                    xdst_c[XD_R]  = 1'b1;
                end else begin
                    aluop_c        = {1'b0, op};
                    xdst_c[XD_R]   = 1'b1;
                    xdst_c[XD_FLG] = 1'b1;
                end
                state_d = ST_ALU1;
            end
            ST_ALU1: begin
                xsrc_c  = XS_R;
                xdst_c  = dst_mask;
                state_d = end_st;
            end
            ST_ADDR: begin
                xsrc_c        = src_sel;
                xdst_c[XD_MA] = 1'b1;
                state_d       = is_ld ? ST_LD : ST_ST0;
            end
            ST_LD: begin
                xsrc_c  = XS_RD;
                xdst_c  = dst_mask;
                state_d = end_st;
            end
            ST_ST0: begin
                xsrc_c        = dst_sel;
                xdst_c[XD_WD] = 1'b1;
                state_d       = ST_ST1;
            end
            ST_ST1: begin
                mem_we_c = 1'b1;
                state_d  = end_st;
            end
            ST_JMP: begin
                // Same cycle count taken or not; only the PC enable changes.
                xsrc_c        = src_sel;
                xdst_c[XD_PC] = cond_true;
                state_d       = end_st;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset forces all controls quiet so the abandoned instruction writes nothing at that edge.
        if (reset) begin
            xsrc_c   = XS_PC;
            xdst_c   = '0;
            aluop_c  = ALU_PASS_B;
            mem_we_c = 1'b0;
        end
    end

    assign xsrc      = xsrc_c;
    assign xdst      = xdst_c;
    assign aluop     = aluop_c;
    assign mem_we    = mem_we_c;
    assign idle      = (state_q == ST_IDLE);
    assign halted    = (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cdecv_control_unit.sv
module tb_cdecv_control_unit;

    logic       clock = 1'b0;
    logic       reset, run, step;
    logic [2:0] xsrc;
    logic [9:0] xdst;
    logic [4:0] aluop;
    logic       mem_we, idle, halted;
    logic [3:0] dbg_state;

    always #5 clock = ~clock;

    // ---------------- datapath environment ----------------
    logic [7:0] pc_q, a_q, b_q, c_q, t_q, r_q, i_q, ma_q, wd_q;
    logic [2:0] flg_q;
    logic [7:0] mem [256];
    int         flg_wr_cnt;

    logic [7:0] init_mem [256];
    logic [7:0] init_a, init_b, init_c;
    logic       ld_en;

    logic [7:0] xbus, alu_res;
    logic [8:0] wide;
    logic [2:0] alu_f;

    cdecv_control_unit dut (
        .clock     (clock),
        .reset     (reset),
        .I         (i_q),
        .SZCy      (flg_q),
        .xsrc      (xsrc),
        .xdst      (xdst),
        .aluop     (aluop),
        .mem_we    (mem_we),
        .run       (run),
        .step      (step),
        .idle      (idle),
        .halted    (halted),
        .dbg_state (dbg_state)
    );

    always_comb begin
        case (xsrc)
            3'd0:    xbus = pc_q;
            3'd1:    xbus = a_q;
            3'd2:    xbus = b_q;
            3'd3:    xbus = c_q;
            3'd4:    xbus = mem[ma_q];
            3'd5:    xbus = r_q;
            3'd6:    xbus = {5'b0, flg_q};
            default: xbus = 8'hFF;
        endcase
        wide = 9'd0;
        case (aluop)
            5'd0:    wide = {1'b0, t_q};
            5'd1:    wide = {1'b0, xbus} + 9'd1;
            5'd2:    wide = {1'b0, xbus} + {1'b0, t_q};
            5'd3:    wide = {1'b0, xbus} - {1'b0, t_q};
            5'd4:    wide = {1'b0, xbus & t_q};
            5'd5:    wide = {1'b0, xbus | t_q};
            5'd6:    wide = {1'b0, xbus ^ t_q};
            default: wide = 9'd0;
        endcase
        alu_res = wide[7:0];
        alu_f   = {wide[7], (wide[7:0] == 8'd0), ((aluop == 5'd2 || aluop == 5'd3) ? wide[8] : 1'b0)};
    end

    always @(posedge clock) begin
        if (reset) begin
            pc_q <= 8'd0; t_q <= 8'd0; r_q <= 8'd0; i_q <= 8'd0;
            ma_q <= 8'd0; wd_q <= 8'd0; flg_q <= 3'd0; flg_wr_cnt <= 0;
            if (ld_en) begin
                a_q <= init_a; b_q <= init_b; c_q <= init_c;
                for (int k = 0; k < 256; k++) mem[k] <= init_mem[k];
            end
        end else begin
            if (xdst[0]) pc_q <= xbus;
            if (xdst[1]) a_q  <= xbus;
            if (xdst[2]) b_q  <= xbus;
            if (xdst[3]) c_q  <= xbus;
            if (xdst[4]) ma_q <= xbus;
            if (xdst[5]) wd_q <= xbus;
            if (xdst[6]) i_q  <= xbus;
            if (xdst[7]) t_q  <= xbus;
            if (xdst[8]) r_q  <= alu_res;
            if (xdst[9]) begin
                flg_q      <= alu_f;
                flg_wr_cnt <= flg_wr_cnt + 1;
            end
            if (mem_we) mem[ma_q] <= wd_q;
        end
    end

    // ---------------- scoreboard ----------------
    localparam int OB_A = 0, OB_C = 1, OB_PC = 2, OB_FLG = 3, OB_FLGCNT = 4, OB_IDLE = 5,
                   OB_HALTED = 6, OB_STATE = 7, OB_XDST = 8, OB_XSRC = 9, OB_ALUOP = 10,
                   OB_MEMWE = 11, OB_LASTLEN = 12, OB_MEM80 = 13, OB_WRQ = 14;

    typedef struct packed {
        logic [7:0] ma;
        logic [7:0] wd;
        logic [7:0] cyc;
    } wr_t;

    string exp_name_q[$];
    int    exp_sel_q[$];
    int    exp_val_q[$];
    wr_t   wr_q[$];

    int checks = 0;
    int errors = 0;
    int busy = 0;
    int last_len = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            OB_A:       return {24'b0, a_q};
            OB_C:       return {24'b0, c_q};
            OB_PC:      return {24'b0, pc_q};
            OB_FLG:     return {29'b0, flg_q};
            OB_FLGCNT:  return flg_wr_cnt;
            OB_IDLE:    return {31'b0, idle};
            OB_HALTED:  return {31'b0, halted};
            OB_STATE:   return {28'b0, dbg_state};
            OB_XDST:    return {22'b0, xdst};
            OB_XSRC:    return {29'b0, xsrc};
            OB_ALUOP:   return {27'b0, aluop};
            OB_MEMWE:   return {31'b0, mem_we};
            OB_LASTLEN: return last_len;
            OB_MEM80:   return {24'b0, mem[8'h80]};
            OB_WRQ:     return wr_q.size();
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: tracks instruction length, checks every memory write, and
    // evaluates queued expectations at the falling edge.
    initial begin
        string       nm;
        int          sel, ev;
        logic [31:0] act;
        wr_t         w;
        forever begin
            @(negedge clock);
            if (reset) busy = 0;
            else if (!idle && !halted) busy = busy + 1;
            else if (busy != 0) begin
                last_len = busy;
                busy = 0;
            end
            if (mem_we) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write: unexpected strobe MA=%h WD=%h, required none", ma_q, wd_q);
                end else begin
                    w = wr_q.pop_front();
                    if (ma_q !== w.ma || wd_q !== w.wd || busy != int'(w.cyc)) begin
                        errors++;
                        $display("FAIL mem_write: got MA=%h WD=%h cycle %0d, required MA=%h WD=%h cycle %0d",
                                 ma_q, wd_q, busy, w.ma, w.wd, w.cyc);
                    end
                end
            end
            while (exp_sel_q.size() > 0) begin
                nm  = exp_name_q.pop_front();
                sel = exp_sel_q.pop_front();
                ev  = exp_val_q.pop_front();
                act = observe(sel);
                checks++;
                if (act !== ev) begin
                    errors++;
                    $display("FAIL %s: got %0h, required %0h", nm, act, ev);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int sel, input int v);
        exp_name_q.push_back(nm);
        exp_sel_q.push_back(sel);
        exp_val_q.push_back(v);
    endtask

    task automatic clear_init();
        for (int k = 0; k < 256; k++) init_mem[k] = 8'h00;
        init_a = 8'h00; init_b = 8'h00; init_c = 8'h00;
    endtask

    task automatic reset_load();
        reset = 1'b1; ld_en = 1'b1;
        tick(1);
        ld_en = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    // One instruction in step mode; optional second step pulse during F1.
    task automatic do_step(input bit glitch);
        int n;
        n = 0;
        step = 1'b1; tick(1); step = 1'b0;   // now F0
        tick(1);                              // now F1
        if (glitch) begin
            step = 1'b1; tick(1); step = 1'b0;
        end
        while (!idle && n < 40) begin
            tick(1);
            n++;
        end
        chk("instr_end_idle", OB_IDLE, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        run = 1'b0; step = 1'b0; ld_en = 1'b0; reset = 1'b1;

        // Reset state
        clear_init();
        reset_load();
        chk("rst_idle", OB_IDLE, 1);
        chk("rst_halted", OB_HALTED, 0);
        chk("rst_state", OB_STATE, 0);
        chk("rst_xdst", OB_XDST, 0);
        chk("rst_memwe", OB_MEMWE, 0);
        tick(2);

        // MOV A,#3 ; ADD A,#5 ; HLT  in run mode
        clear_init();
        init_mem[0] = 8'h13; init_mem[1] = 8'h03; init_mem[2] = 8'h23;
        init_mem[3] = 8'h05; init_mem[4] = 8'hF0;
        run = 1'b1;
        reset_load();
        tick(17);                  // one IDLE cycle, then 8 + 8
        chk("t1_a", OB_A, 8'h08);
        chk("t1_pc", OB_PC, 8'h04);
        chk("t1_flg", OB_FLG, 3'b000);
        chk("t1_flgcnt", OB_FLGCNT, 1);
        chk("t1_next_f0", OB_STATE, 1);
        tick(3);
        chk("t1_halted", OB_HALTED, 1);
        chk("t1_halt_state", OB_STATE, 14);
        chk("t1_halt_xdst", OB_XDST, 0);
        run = 1'b0; step = 1'b1; tick(2); step = 1'b0; run = 1'b1; tick(3);
        chk("t1_halt_stays", OB_HALTED, 1);
        chk("t1_halt_xdst2", OB_XDST, 0);
        chk("t1_halt_pc", OB_PC, 8'h05);
        run = 1'b0;
        reset_load();
        chk("t1_rst_idle", OB_IDLE, 1);
        chk("t1_rst_halted", OB_HALTED, 0);
        tick(1);

        // SUB A,A ; JZ #0x40  (taken) in step mode
        clear_init();
        init_a = 8'h37;
        init_mem[0] = 8'h30; init_mem[1] = 8'hA3; init_mem[2] = 8'h40; init_mem[8'h40] = 8'hF0;
        reset_load();
        do_step(1'b0);
        chk("t2_sub_a", OB_A, 8'h00);
        chk("t2_sub_flg", OB_FLG, 3'b010);
        chk("t2_sub_len", OB_LASTLEN, 6);
        do_step(1'b0);
        chk("t2_jz_pc", OB_PC, 8'h40);
        chk("t2_jz_len", OB_LASTLEN, 6);
        tick(1);

        // ADD A,A ; JZ #0x40  (not taken)
        clear_init();
        init_a = 8'h11;
        init_mem[0] = 8'h20; init_mem[1] = 8'hA3; init_mem[2] = 8'h40;
        reset_load();
        do_step(1'b0);
        chk("t2b_add_a", OB_A, 8'h22);
        chk("t2b_add_flg", OB_FLG, 3'b000);
        do_step(1'b0);
        chk("t2b_jz_pc", OB_PC, 8'h03);
        chk("t2b_jz_len", OB_LASTLEN, 6);
        tick(1);

        // ST B,[0x80] ; LD C,[0x80] ; LD A,[B] ; AND A,C
        clear_init();
        init_b = 8'h5A;
        init_mem[0] = 8'h87; init_mem[1] = 8'h80; init_mem[2] = 8'h7B; init_mem[3] = 8'h80;
        init_mem[4] = 8'h71; init_mem[5] = 8'h42; init_mem[8'h5A] = 8'hC3;
        reset_load();
        wr_q.push_back('{ma: 8'h80, wd: 8'h5A, cyc: 8'd8});
        do_step(1'b0);
        chk("t3_st_len", OB_LASTLEN, 8);
        chk("t3_mem80", OB_MEM80, 8'h5A);
        do_step(1'b0);
        chk("t3_ld_imm_c", OB_C, 8'h5A);
        chk("t3_ld_imm_len", OB_LASTLEN, 7);
        do_step(1'b1);             // extra step during F1 must be ignored
        chk("t3_ld_reg_a", OB_A, 8'hC3);
        chk("t3_ld_reg_len", OB_LASTLEN, 5);
        tick(3);
        chk("t3_still_idle", OB_IDLE, 1);
        chk("t3_pc_held", OB_PC, 8'h05);
        do_step(1'b0);
        chk("t3_and_a", OB_A, 8'h42);
        chk("t3_and_flg", OB_FLG, 3'b000);
        chk("t3_and_pc", OB_PC, 8'h06);
        tick(1);

        // Reset during ALU0 of ADD A,B
        clear_init();
        init_a = 8'h01; init_b = 8'h02;
        init_mem[0] = 8'h21; init_mem[1] = 8'hF0;
        run = 1'b1;
        reset_load();
        tick(5);                   // IDLE, F0, F1, F2, OPND -> now ALU0
        reset = 1'b1;
        chk("t5_in_alu0", OB_STATE, 7);
        chk("t5_xdst_zero", OB_XDST, 0);
        chk("t5_xsrc_zero", OB_XSRC, 0);
        chk("t5_aluop_zero", OB_ALUOP, 0);
        chk("t5_memwe_zero", OB_MEMWE, 0);
        tick(1);
        reset = 1'b0;
        run = 1'b0;
        chk("t5_idle", OB_IDLE, 1);
        chk("t5_state", OB_STATE, 0);
        chk("t5_pc", OB_PC, 8'h00);
        chk("t5_a_kept", OB_A, 8'h01);
        chk("t5_flgcnt", OB_FLGCNT, 0);
        tick(2);

        chk("all_writes_seen", OB_WRQ, 0);
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
